// File: rtl/tape_recorder.sv
// tape_recorder: decodes the PLA cassette square wave into bytes and writes them to SDRAM tape space.
// Define TAPE_REC_CHECKSUM_EN to add an 8-bit running checksum output of acknowledged bytes.
module tape_recorder #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GLITCH_MAX = 1,
  parameter int unsigned SHORT_MAX  = 6,
  parameter int unsigned LONG_MAX   = 20,
  parameter int unsigned IDLE_TICKS = 2000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_tape,
  input  logic              arm,
  input  logic              cass_out,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  input  logic              mem_ack,
  output logic              recording,
  output logic              done,
  output logic [ADDR_W-1:0] length,
  output logic              overrun,
  output logic              frame_err
`ifdef TAPE_REC_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam int unsigned IDLE_W = $clog2(IDLE_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_HUNT, S_DATA, S_STOP, S_DRAIN} state_t;

  state_t              state, next_state;
  logic                cass_q, cass_q2, arm_q;
  logic [CNT_W-1:0]    cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                started, phase, first_long;
  logic [7:0]          shreg;
  logic [2:0]          bit_cnt;
  logic [ADDR_W-1:0]   addr;

  logic rise_c, arm_rise_c, decoding_c, framed_c, edge_c, meas_c;
  logic short_c, long_c, gap_c, pair_c, bit_ok_c, mixed_c, bit_val_c;
  logic timeout_c, end_c;
  logic start_c, byte_done_c, ferr_c, done_c, shift_c, clr_bits_c;

  assign rise_c     = cass_q & ~cass_q2;
  assign arm_rise_c = arm & ~arm_q;
  assign decoding_c = (state == S_HUNT) || (state == S_DATA) || (state == S_STOP);
  assign framed_c   = (state == S_DATA) || (state == S_STOP);
  // The session's first edge is always taken as the measurement start.
  assign edge_c     = decoding_c & rise_c & (~started | (cnt > CNT_W'(GLITCH_MAX)));
  assign meas_c     = edge_c & started;
  assign short_c    = cnt <= CNT_W'(SHORT_MAX);
  assign long_c     = ~short_c & (cnt <= CNT_W'(LONG_MAX));
  assign gap_c      = meas_c & ~short_c & ~long_c;
  assign pair_c     = meas_c & phase & ~gap_c;
  assign bit_ok_c   = pair_c & (first_long == long_c);
  assign mixed_c    = pair_c & (first_long != long_c);
  assign bit_val_c  = ~long_c;
  assign timeout_c  = (idle_cnt == IDLE_W'(IDLE_TICKS)) && (length != '0);
  assign end_c      = decoding_c & (~arm | timeout_c);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Frame sequencing and session control
  always_comb begin
    next_state  = state;
    start_c     = 1'b0;
    byte_done_c = 1'b0;
    ferr_c      = 1'b0;
    done_c      = 1'b0;
    shift_c     = 1'b0;
    clr_bits_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm_rise_c) begin
          start_c    = 1'b1;
          next_state = S_HUNT;
        end
      end
      S_HUNT, S_DATA, S_STOP: begin
        if (end_c) begin
          next_state = S_DRAIN;
        end else if ((gap_c || mixed_c) && framed_c) begin
          ferr_c     = 1'b1;
          next_state = S_HUNT;
        end else if (bit_ok_c) begin
          case (state)
            S_HUNT: begin
              if (!bit_val_c) begin
                clr_bits_c = 1'b1;
                next_state = S_DATA;
              end
            end
            S_DATA: begin
              shift_c = 1'b1;
              if (bit_cnt == 3'd7) begin
                clr_bits_c = 1'b1;
                next_state = S_STOP;
              end
            end
            S_STOP: begin
              if (!bit_val_c) begin
                ferr_c     = 1'b1;
                next_state = S_HUNT;
              end else if (bit_cnt == 3'd1) begin
                byte_done_c = 1'b1;
                next_state  = S_HUNT;
              end
            end
            default: ;
          endcase
        end
      end
      S_DRAIN: begin
        if (!mem_req) begin
          done_c     = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Edge detection, period measurement and cycle pairing
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cass_q     <= 1'b0;
      cass_q2    <= 1'b0;
      arm_q      <= 1'b0;
      cnt        <= '0;
      idle_cnt   <= '0;
      started    <= 1'b0;
      phase      <= 1'b0;
      first_long <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
    end else begin
      cass_q  <= cass_out;
      cass_q2 <= cass_q;
      arm_q   <= arm;
      if (start_c || edge_c)                cnt <= '0;
      else if (ce_tape && (cnt != '1))      cnt <= cnt + CNT_W'(1);
      if (start_c || edge_c)                idle_cnt <= '0;
      else if (ce_tape && decoding_c && (idle_cnt != IDLE_W'(IDLE_TICKS)))
        idle_cnt <= idle_cnt + IDLE_W'(1);
      if (start_c)     started <= 1'b0;
      else if (edge_c) started <= 1'b1;
      if (start_c || gap_c) begin
        phase <= 1'b0;
      end else if (meas_c) begin
        phase      <= ~phase;
        first_long <= long_c;
      end
      if (shift_c)         shreg   <= {bit_val_c, shreg[7:1]};
      if (clr_bits_c)      bit_cnt <= '0;
      else if (bit_ok_c)   bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Single-entry write buffer, address/length bookkeeping and status flags
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      addr      <= '0;
      length    <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      recording <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_c;
      if (start_c) begin
        addr      <= '0;
        length    <= '0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
        recording <= 1'b1;
      end else if (done_c) begin
        recording <= 1'b0;
      end
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        addr    <= addr + ADDR_W'(1);
        length  <= length + ADDR_W'(1);
      end
      if (byte_done_c) begin
        if (mem_req || (addr == '1)) begin
          overrun <= 1'b1;
        end else begin
          mem_req  <= 1'b1;
          mem_data <= shreg;
          mem_addr <= addr;
        end
      end
      if (ferr_c) frame_err <= 1'b1;
    end
  end

`ifdef TAPE_REC_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)               checksum <= '0;
    else if (start_c)           checksum <= '0;
    else if (mem_req && mem_ack) checksum <= checksum + mem_data;
  end
`endif

endmodule

// File: tb/tb_tape_recorder.sv
// tb_tape_recorder: drives cassette waveforms built from the cycle/bit/frame rules and scoreboards the SDRAM writes.
module tb_tape_recorder;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned GLITCH_MAX = 1;
  localparam int unsigned SHORT_MAX  = 6;
  localparam int unsigned LONG_MAX   = 20;

  logic              clk_sys  = 1'b0;
  logic              reset_n  = 1'b0;
  logic              ce_tape  = 1'b0;
  logic              arm      = 1'b0;
  logic              cass_out = 1'b0;
  logic              mem_ack  = 1'b0;
  logic              mem_req, recording, done, overrun, frame_err;
  logic [ADDR_W-1:0] mem_addr, length;
  logic [7:0]        mem_data;
`ifdef TAPE_REC_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  tape_recorder dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ce_tape   (ce_tape),
    .arm       (arm),
    .cass_out  (cass_out),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack),
    .recording (recording),
    .done      (done),
    .length    (length),
    .overrun   (overrun),
    .frame_err (frame_err)
`ifdef TAPE_REC_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  int   model_n = 0;
  logic [7:0] model_ck = '0;
  bit   exp_ovr = 1'b0, exp_ferr = 1'b0, chk_en = 1'b0, ack_hold = 1'b0;
  int   done_cnt = 0;
  bit   req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: write scoreboard, sticky flags, done bookkeeping
  always @(negedge clk_sys) begin
    wr_t w;
    if (reset_n) begin
      if (mem_req && !req_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h with no byte expected", mem_addr, mem_data);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(w.a));
          check("wr_data", 32'(mem_data), 32'(w.d));
        end
      end
      if (chk_en) begin
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
      end
      if (done) begin
        done_cnt++;
        check("recording_at_done", 32'(recording), 32'(0));
      end
    end
    req_prev = mem_req;
  end

  // SDRAM arbiter stand-in: one-clk ack after 0..2 idle clks unless held off
  always begin
    @(negedge clk_sys);
    if (mem_req && !ack_hold) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      mem_ack = 1'b1;
      @(negedge clk_sys);
      mem_ack = 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_sys);
    @(negedge clk_sys);
    @(negedge clk_sys) ce_tape = 1'b1;
    @(negedge clk_sys) ce_tape = 1'b0;
  endtask

  task automatic ftick();
    @(negedge clk_sys) ce_tape = 1'b1;
    @(negedge clk_sys) ce_tape = 1'b0;
  endtask

  // One cassette cycle of p ticks; an optional glitch re-rises within the first tick
  task automatic cyc(input int p, input bit glitch);
    int h;
    h = p / 2;
    cass_out = 1'b1;
    if (glitch) begin
      repeat (2) @(negedge clk_sys);
      cass_out = 1'b0;
      repeat (2) @(negedge clk_sys);
      cass_out = 1'b1;
    end
    repeat (h) tick();
    cass_out = 1'b0;
    repeat (p - h) tick();
  endtask

  function automatic int per(input bit lng, input bit rnd);
    if (!rnd) return lng ? 10 : 4;
    if (lng) return int'($urandom_range(LONG_MAX, SHORT_MAX + 1));
    return int'($urandom_range(SHORT_MAX, GLITCH_MAX + 1));
  endfunction

  // gl: 0 = clean, 1 = glitch every cycle, 2 = glitch on random cycles
  task automatic send_bit(input bit v, input bit rnd, input int gl);
    for (int k = 0; k < 2; k++)
      cyc(per(!v, rnd), (gl == 1) || ((gl == 2) && ($urandom_range(0, 3) == 0)));
  endtask

  task automatic leader(input int n, input bit rnd);
    repeat (n) send_bit(1'b1, rnd, 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit rnd, input int gl);
    send_bit(1'b0, rnd, gl);
    for (int i = 0; i < 8; i++) send_bit(b[i], rnd, gl);
    send_bit(1'b1, rnd, gl);
    send_bit(1'b1, rnd, gl);
  endtask

  task automatic close_edge();
    cass_out = 1'b1;
    tick();
    cass_out = 1'b0;
    tick();
  endtask

  task automatic expect_write(input logic [7:0] b);
    wr_t w;
    w.a = ADDR_W'(model_n);
    w.d = b;
    exp_q.push_back(w);
    model_n++;
    model_ck = model_ck + b;
  endtask

  task automatic start_sess();
    chk_en = 1'b0;
    arm = 1'b1;
    repeat (3) @(negedge clk_sys);
    model_n  = 0;
    model_ck = '0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    check("recording_start", 32'(recording), 32'(1));
    check("length_clear", 32'(length), 32'(0));
    chk_en = 1'b1;
  endtask

  task automatic end_arm();
    int d0;
    d0 = done_cnt;
    arm = 1'b0;
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk_sys);
    repeat (2) @(negedge clk_sys);
    check("done_pulses", 32'(done_cnt - d0), 32'(1));
    check("recording_end", 32'(recording), 32'(0));
    check("length_end", 32'(length), 32'(model_n));
    check("writes_outstanding", 32'(exp_q.size()), 32'(0));
`ifdef TAPE_REC_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(model_ck));
`endif
  endtask

  initial begin
    int d0;
    logic [7:0] b;

    repeat (3) @(negedge clk_sys);
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_recording", 32'(recording), 32'(0));
    check("rst_length", 32'(length), 32'(0));
    check("rst_flags", 32'({overrun, frame_err, done}), 32'(0));
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Leader then 0xA5 at fixed 4/10 tick periods
    start_sess();
    leader(20, 1'b0);
    expect_write(8'hA5);
    send_frame(8'hA5, 1'b0, 0);
    close_edge();
    repeat (10) @(negedge clk_sys);
    check("a5_length", 32'(length), 32'(1));
    end_arm();

    // Three back-to-back frames ended by idle timeout
    start_sess();
    leader(4, 1'b0);
    foreach (exp_q[i]) ;
    expect_write(8'h01);
    expect_write(8'h80);
    expect_write(8'hFF);
    send_frame(8'h01, 1'b0, 0);
    send_frame(8'h80, 1'b0, 0);
    send_frame(8'hFF, 1'b0, 0);
    close_edge();
    d0 = done_cnt;
    for (int i = 0; i < 2100; i++) begin
      if (i == 1900) check("no_early_timeout", 32'(done_cnt - d0), 32'(0));
      ftick();
    end
    repeat (5) @(negedge clk_sys);
    check("timeout_done", 32'(done_cnt - d0), 32'(1));
    check("timeout_recording", 32'(recording), 32'(0));
    check("timeout_length", 32'(length), 32'(3));
    check("timeout_writes", 32'(exp_q.size()), 32'(0));
`ifdef TAPE_REC_CHECKSUM_EN
    check("timeout_checksum", 32'(checksum), 32'(8'h80));
`endif
    arm = 1'b0;
    repeat (3) @(negedge clk_sys);

    // Ack withheld across two frames: second byte dropped
    start_sess();
    chk_en = 1'b0;
    ack_hold = 1'b1;
    leader(4, 1'b0);
    expect_write(8'h11);
    send_frame(8'h11, 1'b0, 0);
    send_frame(8'h22, 1'b0, 0);
    close_edge();
    repeat (10) @(negedge clk_sys);
    check("overrun_set", 32'(overrun), 32'(1));
    exp_ovr = 1'b1;
    chk_en = 1'b1;
    ack_hold = 1'b0;
    repeat (10) @(negedge clk_sys);
    end_arm();

    // Long/short pair inside data bits, then a clean 0x3C
    start_sess();
    chk_en = 1'b0;
    leader(4, 1'b0);
    send_bit(1'b0, 1'b0, 0);
    cyc(10, 1'b0);
    cyc(4, 1'b0);
    leader(4, 1'b0);
    expect_write(8'h3C);
    send_frame(8'h3C, 1'b0, 0);
    close_edge();
    repeat (5) @(negedge clk_sys);
    check("ferr_set", 32'(frame_err), 32'(1));
    exp_ferr = 1'b1;
    chk_en = 1'b1;
    end_arm();

    // Glitch on every cycle of a 0x5A frame
    start_sess();
    leader(4, 1'b0);
    expect_write(8'h5A);
    send_frame(8'h5A, 1'b0, 1);
    close_edge();
    end_arm();

    // Randomised periods, glitches, leaders and bytes
    start_sess();
    leader(6, 1'b1);
    for (int f = 0; f < 8; f++) begin
      b = 8'($urandom_range(0, 255));
      expect_write(b);
      send_frame(b, 1'b1, 2);
      leader(int'($urandom_range(0, 3)), 1'b1);
    end
    close_edge();
    end_arm();

`ifdef TAPE_REC_CHECKSUM_EN
    start_sess();
    leader(4, 1'b0);
    expect_write(8'h80);
    expect_write(8'h90);
    send_frame(8'h80, 1'b0, 0);
    send_frame(8'h90, 1'b0, 0);
    close_edge();
    end_arm();
    check("checksum_literal", 32'(checksum), 32'(8'h10));
`endif

    // Reset while a write is pending
    start_sess();
    chk_en = 1'b0;
    ack_hold = 1'b1;
    leader(4, 1'b0);
    expect_write(8'h77);
    send_frame(8'h77, 1'b0, 0);
    close_edge();
    for (int i = 0; i < 100 && !mem_req; i++) @(negedge clk_sys);
    check("req_before_reset", 32'(mem_req), 32'(1));
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(mem_req), 32'(0));
    check("rst_mid_addr_data", 32'({mem_addr, mem_data}), 32'(0));
    check("rst_mid_recording", 32'(recording), 32'(0));
    check("rst_mid_length", 32'(length), 32'(0));
    check("rst_mid_flags", 32'({overrun, frame_err, done}), 32'(0));
    arm = 1'b0;
    repeat (5) @(negedge clk_sys);
    reset_n = 1'b1;
    ack_hold = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("no_done_after_reset", 32'(done_cnt - d0), 32'(0));
    check("idle_after_reset", 32'({mem_req, recording}), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
